// File: rtl/ram_arbiter_if.sv
// Request, response and engine bus for ram_arbiter.
// Stats ports exist only when RAM_ARB_STATS_EN is defined.
interface ram_arbiter_if;
  logic        wr_req;
  logic [23:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic [1:0]  rd_req;
  logic [23:0] rd_addr0;
  logic [23:0] rd_addr1;
  logic [1:0]  rd_valid;
  logic [15:0] rd_data;
  logic        eng_start;
  logic [47:0] eng_tx;
  logic        eng_done;
  logic [47:0] eng_rx;
  logic        busy;
`ifdef RAM_ARB_STATS_EN
  logic [15:0] stat_wr;
  logic [15:0] stat_rd0;
  logic [15:0] stat_rd1;
  logic [15:0] stat_starve;
`endif

  modport slave (
    input  wr_req, wr_addr, wr_data,
    input  rd_req, rd_addr0, rd_addr1,
    input  eng_done, eng_rx,
`ifdef RAM_ARB_STATS_EN
    output stat_wr, stat_rd0, stat_rd1, stat_starve,
`endif
    output wr_ack, rd_valid, rd_data,
    output eng_start, eng_tx, busy
  );

  modport master (
    output wr_req, wr_addr, wr_data,
    output rd_req, rd_addr0, rd_addr1,
    output eng_done, eng_rx,
`ifdef RAM_ARB_STATS_EN
    input  stat_wr, stat_rd0, stat_rd1, stat_starve,
`endif
    input  wr_ack, rd_valid, rd_data,
    input  eng_start, eng_tx, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Arbiter sharing the serial SRAM engine between one write and two read ports.
// Optional per-port statistics counters enabled by RAM_ARB_STATS_EN.
module ram_arbiter #(
  parameter logic [23:0] RAM_END_ADDR = 24'h01FFFF,
  parameter int unsigned WR_BURST     = 4,
  parameter logic [7:0]  CMD_WRITE    = 8'h02,
  parameter logic [7:0]  CMD_READ     = 8'h03
) (
  input logic          clk,
  input logic          nrst,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(WR_BURST);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  burst;
  logic [3:0]  burst_nxt;
  logic        rr;
  logic        rr_nxt;
  logic        sel_rd;
  logic        sel_port;
  logic        grant;
  logic        grant_rd;
  logic        grant_port;
  logic        starve;
  logic        rd_any;
  logic        wr_win;
  logic        done_ok;
  logic [47:0] frame;
  logic [47:0] frame_nxt;
  logic        start_q;
  logic        ack_q;
  logic [1:0]  valid_q;
  logic [15:0] data_q;
  logic        unused_rx;

  function automatic logic [23:0] wrap(input logic [23:0] a);
    return (a >= RAM_END_ADDR) ? a - RAM_END_ADDR : a;
  endfunction

  assign rd_any  = |bus.rd_req;
  assign wr_win  = bus.wr_req && !(burst == BURST_MAX && rd_any);
  assign done_ok = (state == WAIT) && bus.eng_done;

  assign unused_rx = ^bus.eng_rx[47:16];

  // Next state, arbitration and frame assembly
  always_comb begin
    state_nxt  = state;
    burst_nxt  = burst;
    rr_nxt     = rr;
    grant      = 1'b0;
    grant_rd   = 1'b0;
    grant_port = 1'b0;
    starve     = 1'b0;
    frame_nxt  = frame;
    unique case (state)
      IDLE: begin
        if (wr_win) begin
          grant     = 1'b1;
          starve    = rd_any;
          burst_nxt = rd_any ? burst + 4'd1 : 4'd0;
          frame_nxt = {CMD_WRITE, wrap(bus.wr_addr),
                       bus.wr_data};
          state_nxt = ISSUE;
        end else if (rd_any) begin
          grant      = 1'b1;
          grant_rd   = 1'b1;
          grant_port = (&bus.rd_req) ? rr : bus.rd_req[1];
          rr_nxt     = ~grant_port;
          burst_nxt  = 4'd0;
          frame_nxt  = {CMD_READ,
                        wrap(grant_port ? bus.rd_addr1
                                        : bus.rd_addr0),
                        16'h0000};
          state_nxt  = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (bus.eng_done) state_nxt = RESP;
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, burst counter and round-robin pointer
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      burst <= 4'd0;
      rr    <= 1'b0;
    end else begin
      state <= state_nxt;
      burst <= burst_nxt;
      rr    <= rr_nxt;
    end
  end

  // Latch the winner's frame and identity at grant
  always_ff @(posedge clk) begin
    if (!nrst) begin
      frame    <= 48'h0;
      sel_rd   <= 1'b0;
      sel_port <= 1'b0;
    end else if (grant) begin
      frame    <= frame_nxt;
      sel_rd   <= grant_rd;
      sel_port <= grant_port;
    end
  end

  // Start pulse and completion responses
  always_ff @(posedge clk) begin
    if (!nrst) begin
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      valid_q <= 2'b00;
      data_q  <= 16'h0000;
    end else begin
      start_q <= (state == ISSUE);
      ack_q   <= done_ok && !sel_rd;
      valid_q <= (done_ok && sel_rd)
                 ? (sel_port ? 2'b10 : 2'b01)
                 : 2'b00;
      if (done_ok && sel_rd) data_q <= bus.eng_rx[15:0];
    end
  end

  assign bus.eng_start = start_q;
  assign bus.eng_tx    = frame;
  assign bus.wr_ack    = ack_q;
  assign bus.rd_valid  = valid_q;
  assign bus.rd_data   = data_q;
  assign bus.busy      = (state != IDLE);

`ifdef RAM_ARB_STATS_EN
  logic [15:0] st_wr;
  logic [15:0] st_rd0;
  logic [15:0] st_rd1;
  logic [15:0] st_starve;

  // Saturating completion and starvation counters
  always_ff @(posedge clk) begin
    if (!nrst) begin
      st_wr     <= 16'h0;
      st_rd0    <= 16'h0;
      st_rd1    <= 16'h0;
      st_starve <= 16'h0;
    end else begin
      if (state == RESP) begin
        if (!sel_rd && st_wr != 16'hFFFF)
          st_wr <= st_wr + 16'd1;
        if (sel_rd && !sel_port && st_rd0 != 16'hFFFF)
          st_rd0 <= st_rd0 + 16'd1;
        if (sel_rd && sel_port && st_rd1 != 16'hFFFF)
          st_rd1 <= st_rd1 + 16'd1;
      end
      if (starve && st_starve != 16'hFFFF)
        st_starve <= st_starve + 16'd1;
    end
  end

  assign bus.stat_wr     = st_wr;
  assign bus.stat_rd0    = st_rd0;
  assign bus.stat_rd1    = st_rd1;
  assign bus.stat_starve = st_starve;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter.
// Stats checks are compiled in when RAM_ARB_STATS_EN is defined.
module tb_ram_arbiter;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.wr_req   = 1'b0;
    bus.wr_addr  = 24'h0;
    bus.wr_data  = 16'h0;
    bus.rd_req   = 2'b00;
    bus.rd_addr0 = 24'h0;
    bus.rd_addr1 = 24'h0;
    bus.eng_done = 1'b0;
    bus.eng_rx   = 48'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (bus.eng_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic serve(input logic [15:0] rx,
                       output logic [47:0] tx,
                       output logic wack,
                       output logic [1:0] rv);
    int n;
    wait_start(n);
    tx = bus.eng_tx;
    bus.eng_rx   = {32'hC0DE_0000, rx};
    bus.eng_done = 1'b1;
    @(negedge clk);
    bus.eng_done = 1'b0;
    wack = bus.wr_ack;
    rv   = bus.rd_valid;
  endtask

  task automatic test_reset();
    clear_inputs();
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    checks++;
    if (bus.eng_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_start: got %b want 0", bus.eng_start);
    end
    checks++;
    if (bus.eng_tx !== 48'h0) begin
      errors++;
      $display("FAIL reset_tx: got %h want 0", bus.eng_tx);
    end
    checks++;
    if (bus.wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack: got %b want 0", bus.wr_ack);
    end
    checks++;
    if (bus.rd_valid !== 2'b00) begin
      errors++;
      $display("FAIL reset_valid: got %b want 00", bus.rd_valid);
    end
    checks++;
    if (bus.rd_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 0", bus.rd_data);
    end
    nrst = 1'b1;
  endtask

  task automatic test_single_write();
    int n;
    do_reset();
    bus.wr_req  = 1'b1;
    bus.wr_addr = 24'h000010;
    bus.wr_data = 16'hBEEF;
    wait_start(n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL wr_latency: got %0d want 2", n);
    end
    checks++;
    if (bus.eng_tx !== 48'h02_000010_BEEF) begin
      errors++;
      $display("FAIL wr_frame: got %h want 02000010beef",
               bus.eng_tx);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.eng_start !== 1'b0 || bus.busy !== 1'b1 ||
        bus.eng_tx !== 48'h02_000010_BEEF) begin
      errors++;
      $display("FAIL wr_wait: got start=%b busy=%b tx=%h want 0 1 02000010beef",
               bus.eng_start, bus.busy, bus.eng_tx);
    end
    bus.eng_done = 1'b1;
    @(negedge clk);
    bus.eng_done = 1'b0;
    checks++;
    if (bus.wr_ack !== 1'b1 || bus.rd_valid !== 2'b00) begin
      errors++;
      $display("FAIL wr_ack: got ack=%b valid=%b want 1 00",
               bus.wr_ack, bus.rd_valid);
    end
    bus.wr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wr_ack !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_after: got ack=%b busy=%b want 0 0",
               bus.wr_ack, bus.busy);
    end
  endtask

  task automatic test_early_done();
    logic bad;
    do_reset();
    bus.wr_req   = 1'b1;
    bus.wr_addr  = 24'h000020;
    bus.wr_data  = 16'h1111;
    bus.eng_done = 1'b1;
    @(negedge clk);
    bus.wr_req = 1'b0;
    @(negedge clk);
    bus.eng_done = 1'b0;
    checks++;
    if (bus.eng_start !== 1'b1) begin
      errors++;
      $display("FAIL early_start: got %b want 1", bus.eng_start);
    end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.wr_ack !== 1'b0 || bus.busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL early_done_ignored: got bad=1 want 0");
    end
    bus.eng_done = 1'b1;
    @(negedge clk);
    bus.eng_done = 1'b0;
    checks++;
    if (bus.wr_ack !== 1'b1) begin
      errors++;
      $display("FAIL dropped_req_ack: got %b want 1", bus.wr_ack);
    end
    @(negedge clk);
  endtask

  task automatic test_read_wrap();
    int n;
    do_reset();
    bus.rd_req   = 2'b10;
    bus.rd_addr0 = 24'h000777;
    bus.rd_addr1 = 24'h020005;
    wait_start(n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL rd_latency: got %0d want 2", n);
    end
    checks++;
    if (bus.eng_tx !== 48'h03_000006_0000) begin
      errors++;
      $display("FAIL rd_frame: got %h want 030000060000",
               bus.eng_tx);
    end
    bus.eng_rx   = {32'hDEAD_BEEF, 16'h1234};
    bus.eng_done = 1'b1;
    @(negedge clk);
    bus.eng_done = 1'b0;
    bus.rd_req   = 2'b00;
    checks++;
    if (bus.rd_valid !== 2'b10 || bus.wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_valid: got valid=%b ack=%b want 10 0",
               bus.rd_valid, bus.wr_ack);
    end
    checks++;
    if (bus.rd_data !== 16'h1234) begin
      errors++;
      $display("FAIL rd_data: got %h want 1234", bus.rd_data);
    end
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 2'b00 || bus.rd_data !== 16'h1234) begin
      errors++;
      $display("FAIL rd_hold: got valid=%b data=%h want 00 1234",
               bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_wrap_boundary();
    logic [47:0] tx;
    logic        wack;
    logic [1:0]  rv;
    do_reset();
    bus.wr_req  = 1'b1;
    bus.wr_addr = 24'h01FFFF;
    bus.wr_data = 16'h0042;
    serve(16'h0, tx, wack, rv);
    bus.wr_req = 1'b0;
    checks++;
    if (tx !== 48'h02_000000_0042) begin
      errors++;
      $display("FAIL wrap_equal: got %h want 020000000042", tx);
    end
    bus.rd_req   = 2'b01;
    bus.rd_addr0 = 24'h01FFFE;
    serve(16'h0, tx, wack, rv);
    bus.rd_req = 2'b00;
    checks++;
    if (tx !== 48'h03_01FFFE_0000) begin
      errors++;
      $display("FAIL wrap_below: got %h want 0301fffe0000", tx);
    end
    bus.rd_req   = 2'b01;
    bus.rd_addr0 = 24'hFFFFFF;
    serve(16'h0, tx, wack, rv);
    bus.rd_req = 2'b00;
    checks++;
    if (tx !== 48'h03_FE0000_0000) begin
      errors++;
      $display("FAIL wrap_top: got %h want 03fe00000000", tx);
    end
    @(negedge clk);
  endtask

  task automatic test_burst();
    logic [47:0] tx;
    logic        wack;
    logic [1:0]  rv;
    int          code;
    int          exp_code [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    do_reset();
    bus.wr_req   = 1'b1;
    bus.wr_addr  = 24'h000030;
    bus.wr_data  = 16'h5555;
    bus.rd_req   = 2'b01;
    bus.rd_addr0 = 24'h000040;
    for (int i = 0; i < 10; i++) begin
      serve(16'hA000 + 16'(i), tx, wack, rv);
      code = wack ? 0 : (rv == 2'b01) ? 1 : (rv == 2'b10) ? 2 : 3;
      checks++;
      if (code !== exp_code[i]) begin
        errors++;
        $display("FAIL burst_grant%0d: got %0d want %0d",
                 i, code, exp_code[i]);
      end
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [47:0] tx;
    logic        wack;
    logic [1:0]  rv;
    logic [1:0]  exp_rv;
    logic [23:0] exp_addr;
    do_reset();
    bus.rd_req   = 2'b11;
    bus.rd_addr0 = 24'h000100;
    bus.rd_addr1 = 24'h000200;
    for (int i = 0; i < 4; i++) begin
      serve(16'h0B00 + 16'(i), tx, wack, rv);
      exp_rv   = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (i % 2 == 0) ? 24'h000100 : 24'h000200;
      checks++;
      if (rv !== exp_rv || tx[39:16] !== exp_addr ||
          bus.rd_data !== 16'h0B00 + 16'(i)) begin
        errors++;
        $display("FAIL rr_grant%0d: got rv=%b addr=%h data=%h want %b %h %h",
                 i, rv, tx[39:16], bus.rd_data,
                 exp_rv, exp_addr, 16'h0B00 + 16'(i));
      end
    end
    bus.rd_req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [47:0] tx;
    logic        wack;
    logic [1:0]  rv;
    logic        bad;
    int          n;
    do_reset();
    bus.rd_req   = 2'b01;
    bus.rd_addr0 = 24'h000050;
    serve(16'h5A5A, tx, wack, rv);
    bus.rd_req = 2'b00;
    checks++;
    if (bus.rd_data !== 16'h5A5A) begin
      errors++;
      $display("FAIL mid_pre_rdata: got %h want 5a5a", bus.rd_data);
    end
    @(negedge clk);
    bus.wr_req  = 1'b1;
    bus.wr_addr = 24'h000060;
    bus.wr_data = 16'h7777;
    wait_start(n);
    @(negedge clk);
    nrst       = 1'b0;
    bus.wr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.eng_start !== 1'b0 ||
        bus.eng_tx !== 48'h0 || bus.rd_data !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b start=%b tx=%h rdata=%h want 0 0 0 0",
               bus.busy, bus.eng_start, bus.eng_tx, bus.rd_data);
    end
    nrst         = 1'b1;
    bus.eng_done = 1'b1;
    @(negedge clk);
    bus.eng_done = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.wr_ack !== 1'b0 || bus.rd_valid !== 2'b00 ||
          bus.busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL mid_no_resp: got bad=1 want 0");
    end
  endtask

`ifdef RAM_ARB_STATS_EN
  task automatic test_stats();
    logic [47:0] tx;
    logic        wack;
    logic [1:0]  rv;
    do_reset();
    bus.wr_addr = 24'h000070;
    bus.wr_data = 16'h0101;
    for (int i = 0; i < 3; i++) begin
      bus.wr_req = 1'b1;
      serve(16'h0, tx, wack, rv);
      bus.wr_req = 1'b0;
    end
    bus.rd_addr0 = 24'h000080;
    for (int i = 0; i < 2; i++) begin
      bus.rd_req = 2'b01;
      serve(16'h0, tx, wack, rv);
      bus.rd_req = 2'b00;
    end
    @(negedge clk);
    checks++;
    if (bus.stat_wr !== 16'd3) begin
      errors++;
      $display("FAIL stat_wr: got %0d want 3", bus.stat_wr);
    end
    checks++;
    if (bus.stat_rd0 !== 16'd2) begin
      errors++;
      $display("FAIL stat_rd0: got %0d want 2", bus.stat_rd0);
    end
    checks++;
    if (bus.stat_rd1 !== 16'd0 || bus.stat_starve !== 16'd0) begin
      errors++;
      $display("FAIL stat_rd1_starve: got %0d %0d want 0 0",
               bus.stat_rd1, bus.stat_starve);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_early_done();
    test_read_wrap();
    test_wrap_boundary();
    test_burst();
    test_round_robin();
    test_reset_mid();
`ifdef RAM_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
